// File: rtl/serial_adder_dp.sv
// Bit-serial adder datapath: A and B shift right one bit per Sh, the sum builds up
// in A from the top down, and the carry is kept in a single flip-flop.
//
// state    | meaning
// EMPTY    | after reset, no operands loaded
// LOADED   | operands loaded, no shift done yet
// SHIFT    | addition in progress, 1..W-1 shifts done
// COMPLETE | W shifts done, Acc/Cout hold the result
module serial_adder_dp #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Ld,
    input  logic         Sh,
    input  logic [W-1:0] Ain,
    input  logic [W-1:0] Bin,
    output logic [W-1:0] Acc,
    output logic [W-1:0] Bq,
    output logic         Cout,
    output logic         Done,
    output logic         Busy,
    output logic         Err
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        LOADED   = 2'd1,
        SHIFT    = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          sum_bit;
    logic          carry;

    assign sum_bit = Acc[0] ^ Bq[0] ^ Cout;
    assign carry   = (Acc[0] & Bq[0]) | (Acc[0] & Cout) | (Bq[0] & Cout);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            Acc   <= '0;
            Bq    <= '0;
            Cout  <= 1'b0;
            count <= '0;
            Done  <= 1'b0;
            Busy  <= 1'b0;
            Err   <= 1'b0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            if (Ld) begin
                Acc   <= Ain;
                Bq    <= Bin;
                Cout  <= 1'b0;
                count <= '0;
                state <= LOADED;
                Busy  <= 1'b1;
            end else if (Sh) begin
                if (state == LOADED || state == SHIFT) begin
                    Acc   <= {sum_bit, Acc[W-1:1]};
                    Bq    <= {Bq[0], Bq[W-1:1]};
                    Cout  <= carry;
                    count <= count + 1'b1;
                    // count still holds the pre-shift value, so W-1 means this is shift W
                    if (count == CW'(W - 1)) begin
                        state <= COMPLETE;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                    end else begin
                        state <= SHIFT;
                        Busy  <= 1'b1;
                    end
                end else begin
                    Err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/serial_adder_dp.md
SERIAL_ADDER_DP -- requirements
Module: serial_adder_dp

Interface
REQ-001 SHALL have parameter W, default 4, giving the operand width in bits (W >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port Ld, input, 1 bit: load the operands and clear the carry and the shift count.
REQ-005 SHALL have port Sh, input, 1 bit: perform one serial add/shift step; driven by the upstream shift-control FSM.
REQ-006 SHALL have port Ain, input, W bits: addend A, sampled on Ld.
REQ-007 SHALL have port Bin, input, W bits: addend B, sampled on Ld.
REQ-008 SHALL have port Acc, output, W bits: the accumulator, which holds the sum after W shifts.
REQ-009 SHALL have port Bq, output, W bits: the B register.
REQ-010 SHALL have port Cout, output, 1 bit: the carry flip-flop.
REQ-011 SHALL have port Done, output, 1 bit: a one-cycle pulse when the sum is complete.
REQ-012 SHALL have port Busy, output, 1 bit: high while in LOADED or SHIFT.
REQ-013 SHALL have port Err, output, 1 bit: a one-cycle pulse when Sh is ignored.

Function
REQ-014 SHALL implement a registered state machine with states EMPTY, LOADED, SHIFT and COMPLETE.
REQ-015 SHALL, when Ld=1 in any state, set A<=Ain, B<=Bin, C<=0 and count<=0, and move to LOADED.
REQ-016 SHALL give Ld priority over Sh when both are high in the same cycle; no shift occurs in that cycle.
REQ-017 SHALL, on Sh=1 with Ld=0 in LOADED or SHIFT, compute s = A[0]^B[0]^C and carry = majority(A[0],B[0],C).
REQ-018 SHALL, on the same shift, update A<={s, A[W-1:1]}, B<={B[0], B[W-1:1]} (rotate right), C<=carry and count<=count+1.
REQ-019 SHALL, after a shift, move LOADED to SHIFT, and move SHIFT to COMPLETE on the W-th shift (count reaching W).
REQ-020 SHALL assert Done for exactly one cycle: the cycle following the edge that performs the W-th shift.
REQ-021 SHALL, in COMPLETE, hold Acc = (Ain+Bin) mod 2^W, Cout = the carry out of bit W-1, and Bq = Bin (restored by W rotations).
REQ-022 SHALL accept non-consecutive Sh; cycles with Sh=0 hold all registers and the state unchanged.
REQ-023 SHALL ignore Sh=1 (with Ld=0) in EMPTY or COMPLETE, leaving registers unchanged and pulsing Err high for the following cycle.
REQ-024 SHALL size the count register at clog2(W+1) bits so that it never wraps; count is internal only.
REQ-025 SHALL drive Acc, Bq, Cout, Done, Busy and Err directly from registers, with no combinational path from any input to any output.
REQ-026 SHALL, on a Ld issued mid-operation in SHIFT, abort the current addition without asserting Done or Err.

Reset
REQ-027 SHALL, when rst=1 at a rising clk edge, set state=EMPTY, A=0, B=0, C=0, count=0, Done=0, Busy=0 and Err=0.
REQ-028 SHALL give rst priority over Ld and Sh.
REQ-029 SHALL, on reset mid-operation, discard partial results and assert no Done pulse.

Verification
REQ-030 SHALL be verified by: Ld with Ain=0101 and Bin=0011, then 4 consecutive Sh -> Acc=1000, Cout=0, Bq=0011, Done high for 1 cycle, Busy low after.
REQ-031 SHALL be verified by: Ld with Ain=1111 and Bin=0001, then 4 Sh with 1-cycle gaps between them -> Acc=0000, Cout=1, Done for exactly 1 cycle after the 4th Sh.
REQ-032 SHALL be verified by: Ain=0110 and Bin=0101, 2 Sh, then Ld with Ain=0010 and Bin=0010, then 4 Sh -> no Done after the first 2 Sh; final Acc=0100, Cout=0.
REQ-033 SHALL be verified by: Sh pulses after reset (EMPTY) and 1 extra Sh after COMPLETE -> Err pulses once for each; Acc and Cout unchanged.
REQ-034 SHALL be verified by: Ld and Sh high together with Ain=0001 and Bin=0001 -> state LOADED, count 0, A=0001, no shift; then 4 Sh -> Acc=0010.
REQ-035 SHALL be verified by: rst=1 after 3 shifts, then the full upstream FSM sequence (N pulse giving 4 Sh cycles) after Ld with Ain=1001 and Bin=0111 -> all outputs 0 at reset; final Acc=0000, Cout=1.
